scan_decoder: RTL

- Parametrised, registered successor of the fixed 4-to-16 decoder.
- Drives a one-hot output vector of 2**SEL_W lines from a stored index.
- Direct mode: decodes a loaded select value.
- Scan mode: auto-steps through all outputs with a programmable dwell, for display-digit and row scanning.
- Sits between control logic and multiplexed peripherals (7-segment digit enables, LED/keypad rows).

---
 rtl/scan_decoder_if.sv | 25 ++
 rtl/scan_decoder.sv | 72 +++++++
 2 files changed

// File: rtl/scan_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : scan_decoder_if
//  Description : Control/result bundle for the scan decoder. The controller
//                (master) drives enable, mode and load/select; the decoder
//                (slave) returns the one-hot lines, stored index and wrap.
//  Revision    : 1.0  initial release
// ============================================================================
interface scan_decoder_if #(
    parameter int SEL_W = 4
);
    localparam int OUT_W = 2**SEL_W;

    logic             en;
    logic             mode;
    logic             load;
    logic [SEL_W-1:0] sel;
    logic [OUT_W-1:0] d;
    logic [SEL_W-1:0] idx;
    logic             wrap;

    modport master (output en, mode, load, sel, input  d, idx, wrap);
    modport slave  (input  en, mode, load, sel, output d, idx, wrap);
endinterface
`default_nettype wire

// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : scan_decoder
//  Description : Registered one-hot decoder with a stored index. Direct mode
//                decodes a loaded select; scan mode steps the index through
//                all outputs, dwelling DIV cycles on each, and pulses wrap on
//                the OUT_W-1 -> 0 step.
//  Revision    : 1.0  initial release
// ============================================================================
module scan_decoder #(
    parameter int SEL_W = 4,
    parameter int DIV   = 4,
    parameter int CNT_W = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    scan_decoder_if.slave    bus
);
    localparam int               OUT_W      = 2**SEL_W;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [SEL_W-1:0] C_IDX_LAST = SEL_W'(OUT_W - 1);
    localparam logic [OUT_W-1:0] C_ONE      = OUT_W'(1);

    logic [OUT_W-1:0] d_q,    d_d;
    logic [SEL_W-1:0] idx_q,  idx_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             wrap_q, wrap_d;

    // Next-state: enable gate beats load, load beats a scan step, else hold.
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        d_d    = C_ONE << idx_q;   // re-asserts the line after an en=0 blank
        if (!bus.en) begin
            d_d = '0;              // index and dwell counter freeze
        end else if (bus.load) begin
            idx_d = bus.sel;
            cnt_d = '0;
            d_d   = C_ONE << bus.sel;
        end else if (bus.mode) begin
            if (cnt_q == C_CNT_LAST) begin
                cnt_d  = '0;
                idx_d  = idx_q + 1'b1;   // natural wrap modulo OUT_W
                wrap_d = (idx_q == C_IDX_LAST);
                d_d    = C_ONE << idx_d;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q    <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            d_q    <= d_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.d    = d_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
endmodule
`default_nettype wire
